uart_mmio: RTL and testbench

//   Memory-mapped 8N1 UART peripheral on the data-memory bus of the single-cycle

---
 rtl/uart_mmio.sv | 270 +++++++++++++++++++++++++++
 tb/tb_uart_mmio.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: TXDATA / RXDATA / STATUS window on the data-memory bus,
// with a transmit shifter, a 2-flop synchronised receiver and an RX FIFO.
module uart_mmio #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
  parameter int unsigned CLKS_PER_BIT = 10416,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_we,
  input  logic        mem_re,
  output logic [31:0] mem_rdata,
  output logic        sel,
  input  logic        rx,
  output logic        tx
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;

  // ---------------- address decode ----------------
  logic [1:0] off;
  logic       in_win;
  logic       wr_tx;
  logic       rd_rx;
  logic       rd_stat;
  logic       unused_bits;

  assign off         = mem_addr[3:2];
  assign in_win      = (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign sel         = in_win && (off != 2'b11);
  assign wr_tx       = mem_we && sel && (off == 2'b00);
  assign rd_rx       = mem_re && sel && (off == 2'b01);
  assign rd_stat     = mem_re && sel && (off == 2'b10);
  assign unused_bits = ^{mem_wdata[31:8], mem_addr[1:0]};

  // ---------------- transmitter ----------------
  tx_state_e     tx_state_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_shift_q;
  logic          tx_q;
  logic          tx_busy;

  assign tx      = tx_q;
  assign tx_busy = (tx_state_q != TX_IDLE);

  // TX FSM: each of start, 8 data and stop bits is held for CLKS_PER_BIT cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (wr_tx) begin
            tx_shift_q <= mem_wdata[7:0];
            tx_cnt_q   <= '0;
            tx_q       <= 1'b0;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt_q == BIT_END) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_q       <= tx_shift_q[0];
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            tx_state_q <= TX_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt_q == BIT_END) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              tx_q       <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              tx_bit_q   <= tx_bit_q + 1'b1;
              tx_q       <= tx_shift_q[0];
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt_q == BIT_END) begin
            tx_cnt_q   <= '0;
            tx_state_q <= TX_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic rx_s1_q;
  logic rx_s2_q;
  logic rx_prev_q;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  rx_state_e     rx_state_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  logic          rx_push;
  logic          rx_frame_err;

  assign rx_push      = (rx_state_q == RX_STOP) && (rx_cnt_q == BIT_END) && rx_s2_q;
  assign rx_frame_err = (rx_state_q == RX_STOP) && (rx_cnt_q == BIT_END) && !rx_s2_q;

  // RX FSM: half-bit wait to the start-bit centre, then one sample per bit period
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_s2_q) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt_q == HALF_END) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == BIT_END) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) begin
              rx_state_q <= RX_STOP;
            end else begin
              rx_bit_q <= rx_bit_q + 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == BIT_END) begin
            rx_cnt_q   <= '0;
            rx_state_q <= rx_s2_q ? RX_IDLE : RX_WAIT;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_WAIT: begin
          if (rx_s2_q) begin
            rx_state_q <= RX_IDLE;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO and sticky flags ----------------
  logic [7:0]  fifo_mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        overrun_q, overrun_d;
  logic        frame_err_q, frame_err_d;
  logic        rx_empty;
  logic        rx_full;
  logic        pop;
  logic        push_ok;

  assign rx_empty = (rptr_q == wptr_q);
  assign rx_full  = (rptr_q[AW-1:0] == wptr_q[AW-1:0]) && (rptr_q[AW] != wptr_q[AW]);
  assign pop      = rd_rx && !rx_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign push_ok  = rx_push && (!rx_full || pop);

  // Next pointers and flags; a flag being set wins over a same-cycle STATUS clear
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    if (push_ok) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (rd_stat) begin
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
    end
    if (rx_push && rx_full && !pop) begin
      overrun_d = 1'b1;
    end
    if (rx_frame_err) begin
      frame_err_d = 1'b1;
    end
  end

  // Pointer and flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  // FIFO storage; contents are only visible through the pointers, so no reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem_q[wptr_q[AW-1:0]] <= rx_shift_q;
    end
  end

  // Combinational read mux for the addressed register
  always_comb begin
    mem_rdata = '0;
    if (sel) begin
      case (off)
        2'b01:   mem_rdata = rx_empty ? '1 : {24'b0, fifo_mem_q[rptr_q[AW-1:0]]};
        2'b10:   mem_rdata = {27'b0, frame_err_q, overrun_q, rx_full, rx_empty, tx_busy};
        default: mem_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio with CLKS_PER_BIT = 4 and FIFO_DEPTH = 4.
module tb_uart_mmio;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0400;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re, sel, rx, tx;

  int checks = 0;
  int errors = 0;

  logic [7:0]  sb_q[$];
  int unsigned model_cnt = 0;
  logic        model_overrun = 1'b0;
  logic        model_ferr = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_rdata;
    logic        exp_sel;
  } vec_t;
  vec_t vecs[8];

  uart_mmio #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_re   (mem_re),
    .mem_rdata(mem_rdata),
    .sel      (sel),
    .rx       (rx),
    .tx       (tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    return {27'b0, model_ferr, model_overrun, (model_cnt == DEPTH), (model_cnt == 0), 1'b0};
  endfunction

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    mem_addr  = addr;
    mem_wdata = data;
    mem_we    = 1'b1;
    mem_re    = 1'b0;
    @(negedge clk);
    mem_we    = 1'b0;
    mem_addr  = BASE + 32'h8;
  endtask

  task automatic load(input logic [31:0] addr, input logic re, output logic [31:0] data);
    @(negedge clk);
    mem_addr = addr;
    mem_re   = re;
    #1 data  = mem_rdata;
    @(posedge clk);
    #1;
    mem_re   = 1'b0;
    mem_addr = BASE + 32'h8;
  endtask

  task automatic peek_status(input string name);
    logic [31:0] d;
    load(BASE + 32'h8, 1'b0, d);
    check(name, d, exp_status());
  endtask

  task automatic clear_status(input string name);
    logic [31:0] d;
    load(BASE + 32'h8, 1'b1, d);
    check(name, d, exp_status());
    model_ferr    = 1'b0;
    model_overrun = 1'b0;
  endtask

  task automatic read_rx(input string name);
    logic [31:0] d;
    load(BASE + 32'h4, 1'b1, d);
    if (sb_q.size() == 0) begin
      check(name, d, 32'hFFFF_FFFF);
    end else begin
      check(name, d, {24'b0, sb_q.pop_front()});
      model_cnt--;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    if (stop_bit) begin
      if (model_cnt < DEPTH) begin
        sb_q.push_back(b);
        model_cnt++;
      end else begin
        model_overrun = 1'b1;
      end
    end else begin
      model_ferr = 1'b1;
    end
    repeat (CPB + 2) @(negedge clk);
  endtask

  initial begin
    logic [9:0] frame;
    logic [7:0] burst [5];

    mem_addr  = BASE + 32'h8;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    rx        = 1'b1;

    vecs[0] = '{32'h0000_0400, 32'h0000_0000, 1'b1};
    vecs[1] = '{32'h0000_0404, 32'hFFFF_FFFF, 1'b1};
    vecs[2] = '{32'h0000_0408, 32'h0000_0002, 1'b1};
    vecs[3] = '{32'h0000_040A, 32'h0000_0002, 1'b1};
    vecs[4] = '{32'h0000_040C, 32'h0000_0000, 1'b0};
    vecs[5] = '{32'h0000_0410, 32'h0000_0000, 1'b0};
    vecs[6] = '{32'h0000_03FC, 32'h0000_0000, 1'b0};
    vecs[7] = '{32'h0000_1408, 32'h0000_0000, 1'b0};

    repeat (3) @(negedge clk);
    reset = 1'b1;

    // reset state and address decode
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      mem_addr = vecs[i].addr;
      mem_re   = 1'b0;
      #1;
      check($sformatf("decode_rdata[%0d]", i), mem_rdata, vecs[i].exp_rdata);
      check($sformatf("decode_sel[%0d]", i), {31'b0, sel}, {31'b0, vecs[i].exp_sel});
    end
    check("reset_tx", {31'b0, tx}, 32'h1);

    // TX frame of 0x41, with a dropped store in the middle
    frame = {1'b1, 8'h41, 1'b0};
    store(BASE, 32'h41);
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      mem_we   = 1'b0;
      mem_addr = BASE + 32'h8;
      #1;
      check($sformatf("tx_bit[%0d]", i), {31'b0, tx}, {31'b0, frame[i / 4]});
      check($sformatf("tx_busy[%0d]", i), {31'b0, mem_rdata[0]}, 32'h1);
      if (i == 10) begin
        mem_addr  = BASE;
        mem_wdata = 32'hFF;
        mem_we    = 1'b1;
      end
    end
    for (int i = 40; i < 52; i++) begin
      @(negedge clk);
      mem_we   = 1'b0;
      mem_addr = BASE + 32'h8;
      #1;
      check($sformatf("tx_idle[%0d]", i), {31'b0, tx}, 32'h1);
      check($sformatf("tx_busy_idle[%0d]", i), {31'b0, mem_rdata[0]}, 32'h0);
    end

    // single RX byte
    peek_status("rx_status_before");
    send_frame(8'hA5, 1'b1);
    peek_status("rx_status_after");
    read_rx("rx_a5");
    read_rx("rx_empty_read");

    // overflow: five frames into a four-entry FIFO
    burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) send_frame(burst[i], 1'b1);
    peek_status("ovf_status");
    clear_status("ovf_status_clear");
    peek_status("ovf_status_cleared");
    for (int i = 0; i < 5; i++) read_rx($sformatf("ovf_read[%0d]", i));
    peek_status("ovf_status_drained");

    // framing error
    send_frame(8'h5A, 1'b0);
    peek_status("ferr_status");
    read_rx("ferr_fifo_unchanged");
    clear_status("ferr_status_clear");
    peek_status("ferr_status_cleared");

    // one-cycle glitch, then a good frame to show the receiver recovered
    @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (12) @(negedge clk);
    peek_status("glitch_status");
    read_rx("glitch_no_push");
    send_frame(8'h3C, 1'b1);
    read_rx("post_glitch_3c");

    // reset in the middle of a TX frame
    store(BASE, 32'h41);
    repeat (9) @(negedge clk);
    #1;
    check("midtx_low", {31'b0, tx}, 32'h0);
    #2 reset = 1'b0;
    #1;
    check("reset_tx_async", {31'b0, tx}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    model_cnt     = 0;
    model_overrun = 1'b0;
    model_ferr    = 1'b0;
    sb_q.delete();
    peek_status("post_reset_status");
    repeat (8) @(negedge clk);
    #1;
    check("post_reset_tx", {31'b0, tx}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
